// File: rtl/perf_run_monitor.sv
// Run-control and performance counters for the mipse core: counts cycles, stalls
// and generic events during a run, ends it on the halt store or a cycle budget.
module perf_run_monitor #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       CNT_W     = 32,
  parameter int unsigned       NUM_EV    = 4,
  parameter logic [DATA_W-1:0] HALT_ADDR = DATA_W'(32'h0000_7fff),
  parameter int unsigned       MAX_CYC   = 100000,
  parameter bit                SAT       = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr,
  input  logic              stall,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] writedata,
  input  logic [NUM_EV-1:0] events,
  input  logic [3:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic              ovf,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned NCNT = NUM_EV + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t                     state_q, state_d;
  logic [NCNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;
  logic [DATA_W-1:0]          result_q, result_d;
  logic [CNT_W-1:0]           rd_data_q, rd_data_d;
  logic                       running_q, done_q, timeout_q;
  logic [NCNT-1:0]            inc;
  logic                       halt;
  logic                       budget_hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    rd_data_d  = '0;
    // slot 0 = cycles, slot 1 = stalls, slots 2.. = generic events
    inc        = {events, stall, 1'b1};
    halt       = memwrite && (aluout == HALT_ADDR);
    // compared wide so a budget beyond the counter range is simply never reached
    budget_hit = (64'(cnt_q[0]) + 64'd1) == 64'(MAX_CYC);

    for (int unsigned i = 0; i < NCNT; i++) begin
      if (rd_sel == 4'(i)) rd_data_d = cnt_q[i];
    end

    if (state_q == S_RUN) begin
      for (int unsigned i = 0; i < NCNT; i++) begin
        if (inc[i]) begin
          if (cnt_q[i] == '1) begin
            ovf_d    = 1'b1;
            cnt_d[i] = SAT ? cnt_q[i] : '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end

    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (halt) begin
          state_d  = S_DONE;
          result_d = writedata;
        end else if (budget_hit) begin
          state_d = S_TIMEOUT;
        end
      end
      default: ;
    endcase

    if (clr) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      rd_data_q <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
      rd_data_q <= rd_data_d;
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
      timeout_q <= (state_d == S_TIMEOUT);
    end
  end

  assign rd_data = rd_data_q;
  assign running = running_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign ovf     = ovf_q;
  assign result  = result_q;

endmodule

// File: tb/tb_perf_run_monitor.sv
// Bench for perf_run_monitor: three configurations driven in lockstep, checked
// against an unbounded-count reference model plus directed expectations.
module tb_perf_run_monitor;

  localparam int          NEV  = 4;
  localparam logic [31:0] HALT = 32'h0000_7fff;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr = 1'b0;
  logic        stall = 1'b0, memwrite = 1'b0;
  logic [31:0] aluout = '0, writedata = '0;
  logic [NEV-1:0] events = '0;
  logic [3:0]  rd_sel = '0;
  logic [2:0]  running, done, timeout, ovf;
  logic [31:0] rd_a, res_a, res_b, res_c;
  logic [3:0]  rd_b, rd_c;

  int checks = 0, passes = 0, fails = 0;

  // model configuration per instance: a = 32-bit/MAX_CYC 20, b = 4-bit sat, c = 4-bit wrap
  int unsigned     cw   [3] = '{32, 4, 4};
  bit              msat [3] = '{1'b1, 1'b1, 1'b0};
  longint unsigned mmax [3] = '{64'd20, 64'd100000, 64'd100000};
  int              mst  [3];
  longint unsigned raw  [3][6];
  longint unsigned mres [3];
  longint unsigned mrd  [3];

  always #5 clk = ~clk;

  perf_run_monitor #(.MAX_CYC(20)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .stall(stall),
    .memwrite(memwrite), .aluout(aluout), .writedata(writedata), .events(events),
    .rd_sel(rd_sel), .rd_data(rd_a), .running(running[0]), .done(done[0]),
    .timeout(timeout[0]), .ovf(ovf[0]), .result(res_a));

  perf_run_monitor #(.CNT_W(4), .SAT(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .stall(stall),
    .memwrite(memwrite), .aluout(aluout), .writedata(writedata), .events(events),
    .rd_sel(rd_sel), .rd_data(rd_b), .running(running[1]), .done(done[1]),
    .timeout(timeout[1]), .ovf(ovf[1]), .result(res_b));

  perf_run_monitor #(.CNT_W(4), .SAT(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .stall(stall),
    .memwrite(memwrite), .aluout(aluout), .writedata(writedata), .events(events),
    .rd_sel(rd_sel), .rd_data(rd_c), .running(running[2]), .done(done[2]),
    .timeout(timeout[2]), .ovf(ovf[2]), .result(res_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned lim(int i);
    return (64'd1 << cw[i]) - 64'd1;
  endfunction

  // visible counter value derived from the true number of counted events
  function automatic longint unsigned vis(int i, longint unsigned r);
    if (r <= lim(i)) return r;
    return msat[i] ? lim(i) : r % (lim(i) + 64'd1);
  endfunction

  function automatic bit movf(int i);
    for (int k = 0; k < 6; k++) if (raw[i][k] > lim(i)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mzero();
    for (int i = 0; i < 3; i++) begin
      mst[i] = 0; mres[i] = 0; mrd[i] = 0;
      for (int k = 0; k < 6; k++) raw[i][k] = 0;
    end
  endtask

  task automatic mstep();
    for (int i = 0; i < 3; i++) begin
      mrd[i] = (rd_sel < 4'd6) ? vis(i, raw[i][rd_sel]) : 64'd0;
      if (clr) begin
        mst[i] = 0; mres[i] = 0;
        for (int k = 0; k < 6; k++) raw[i][k] = 0;
      end else if (mst[i] == 0) begin
        if (start) mst[i] = 1;
      end else if (mst[i] == 1) begin
        raw[i][0]++;
        if (stall) raw[i][1]++;
        for (int k = 0; k < NEV; k++) if (events[k]) raw[i][2+k]++;
        if (memwrite && aluout == HALT) begin
          mst[i] = 2; mres[i] = 64'(writedata);
        end else if (raw[i][0] == mmax[i]) begin
          mst[i] = 3;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] rdo [3];
    logic [63:0] rso [3];
    rdo[0] = 64'(rd_a); rdo[1] = 64'(rd_b); rdo[2] = 64'(rd_c);
    rso[0] = 64'(res_a); rso[1] = 64'(res_b); rso[2] = 64'(res_c);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("running[%0d]", i), 64'(running[i]), 64'(mst[i] == 1));
      chk($sformatf("done[%0d]", i),    64'(done[i]),    64'(mst[i] == 2));
      chk($sformatf("timeout[%0d]", i), 64'(timeout[i]), 64'(mst[i] == 3));
      chk($sformatf("ovf[%0d]", i),     64'(ovf[i]),     64'(movf(i)));
      chk($sformatf("result[%0d]", i),  rso[i], mres[i]);
      chk($sformatf("rd_data[%0d]", i), rdo[i], mrd[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    mstep();
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] ev_exp [4];
    ev_exp[0] = 6; ev_exp[1] = 0; ev_exp[2] = 6; ev_exp[3] = 0;

    mzero();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // run with two stall cycles ending on the halt store
    start = 1'b1; cycle(); start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      stall = (c == 3 || c == 4);
      cycle();
    end
    stall = 1'b0; memwrite = 1'b1; aluout = HALT; writedata = 32'hDEAD_BEEF;
    cycle();
    memwrite = 1'b0; aluout = '0;
    chk("t1_done", 64'(done[0]), 64'd1);
    chk("t1_running", 64'(running[0]), 64'd0);
    chk("t1_result", 64'(res_a), 64'hDEAD_BEEF);
    rd_sel = 4'd0; cycle();
    chk("t1_cyc", 64'(rd_a), 64'd11);
    rd_sel = 4'd1; cycle();
    chk("t1_stl", 64'(rd_a), 64'd2);

    // budget exhaustion; 4-bit instances saturate / wrap over the same run
    clr = 1'b1; cycle(); clr = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (20) cycle();
    chk("t2_timeout", 64'(timeout[0]), 64'd1);
    rd_sel = 4'd0; cycle();
    chk("t2_cyc", 64'(rd_a), 64'd20);
    chk("t2_sat_cyc", 64'(rd_b), 64'd15);
    chk("t2_wrap_cyc", 64'(rd_c), 64'd4);
    chk("t2_sat_ovf", 64'(ovf[1]), 64'd1);
    chk("t2_wrap_ovf", 64'(ovf[2]), 64'd1);
    repeat (3) cycle();
    chk("t2_cyc_frozen", 64'(rd_a), 64'd20);

    // halt store on the budget cycle
    clr = 1'b1; cycle(); clr = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (19) cycle();
    memwrite = 1'b1; aluout = HALT; writedata = 32'h1234_5678;
    cycle();
    memwrite = 1'b0; aluout = '0;
    chk("t3_done", 64'(done[0]), 64'd1);
    chk("t3_timeout", 64'(timeout[0]), 64'd0);
    chk("t3_result", 64'(res_a), 64'h1234_5678);

    // generic events and readout select
    clr = 1'b1; cycle(); clr = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    events = 4'b0101;
    repeat (6) cycle();
    events = '0; memwrite = 1'b1; aluout = HALT; writedata = '0;
    cycle();
    memwrite = 1'b0; aluout = '0;
    for (int s = 2; s <= 5; s++) begin
      rd_sel = 4'(s); cycle();
      chk($sformatf("t4_ev%0d", s - 2), 64'(rd_a), 64'(ev_exp[s-2]));
    end
    rd_sel = 4'd9; cycle();
    chk("t4_sel9", 64'(rd_a), 64'd0);

    // clr beats start in DONE
    clr = 1'b1; start = 1'b1; cycle(); clr = 1'b0; start = 1'b0;
    chk("t5_idle_running", 64'(running[0]), 64'd0);
    chk("t5_idle_done", 64'(done[0]), 64'd0);
    rd_sel = 4'd0; cycle();
    chk("t5_cyc_cleared", 64'(rd_a), 64'd0);

    // near-miss stores do not end the run
    start = 1'b1; cycle(); start = 1'b0;
    memwrite = 1'b1; aluout = 32'h0000_7ffe; cycle();
    memwrite = 1'b0; aluout = HALT; cycle();
    aluout = '0;
    chk("t6_running", 64'(running[0]), 64'd1);

    // asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    mzero();
    check_all();
    chk("t6_rst_running", 64'(running[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      start     = ($urandom % 8) == 0;
      clr       = ($urandom % 50) == 0;
      stall     = 1'($urandom);
      events    = NEV'($urandom);
      memwrite  = ($urandom % 5) == 0;
      aluout    = (($urandom % 8) == 0) ? HALT : 32'($urandom_range(32'h7ff0, 32'h800f));
      writedata = $urandom;
      rd_sel    = 4'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/perf_run_monitor.md
Name: perf_run_monitor

Overview:
Synthesizable run-control and performance-counter block for the mipse core. It sits beside the core on the data-memory bus. It counts cycles, stall cycles and NUM_EV generic events, and detects the program-end store (memwrite to HALT_ADDR). It latches the end-of-run result word and aborts runs that exceed a cycle budget. Counters are read back through a registered select port, so the run statistics are available in silicon, not only in simulation.

Parameters:
DATA_W, 32, width of the aluout, writedata and result buses
CNT_W, 32, width of every counter
NUM_EV, 4, number of generic event inputs (1..14)
HALT_ADDR, 32'h0000_7fff, full-width store address that ends a run
MAX_CYC, 100000, cycle budget; reaching it ends the run as a timeout
SAT, 1, 1 = counters saturate at all-ones; 0 = counters wrap to zero

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run (honoured in IDLE only)
clr  in  1  synchronous clear of counters, flags and result; returns to IDLE
stall  in  1  core stall indication
memwrite  in  1  core data-store strobe
aluout  in  DATA_W  core data address
writedata  in  DATA_W  core store data
event  in  NUM_EV  generic event strobes, one count per cycle high
rd_sel  in  4  readout select
rd_data  out  CNT_W  registered counter readout
running  out  1  high in RUN
done  out  1  high in DONE (halt store seen)
timeout  out  1  high in TIMEOUT
ovf  out  1  sticky: some counter saturated or wrapped
result  out  DATA_W  writedata captured on the halt store

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All counters 0. rd_data, result, ovf, running, done and timeout all 0.
- States: IDLE, RUN, DONE, TIMEOUT. Outputs running, done and timeout are decoded from the state register, so they are mutually exclusive.
- IDLE -> RUN on start. start is ignored in every other state.
- RUN -> DONE when memwrite is high and aluout == HALT_ADDR (full-width compare). On that edge result <= writedata.
- RUN -> TIMEOUT on the edge where the cycle counter increments to MAX_CYC.
- Halt store and timeout in the same cycle: DONE wins. result is captured and timeout stays 0.
- DONE and TIMEOUT hold until clr or reset. Counters freeze in both states.
- clr (any state): next edge sets all counters, ovf and result to 0 and the state to IDLE. clr has priority over start, halt and timeout in the same cycle.
- Counting happens in RUN only, including the cycle that causes the DONE or TIMEOUT transition:
  - cyc increments every cycle.
  - stl increments when stall is high.
  - ev[k] increments when event[k] is high.
  - The RUN-entry cycle (start sampled in IDLE) is not counted.
- Width rule: a counter at all-ones (2^CNT_W-1) that increments:
  - SAT=1: holds its value.
  - SAT=0: goes to 0.
  - In both modes ovf is set and stays set until clr or reset.
- Readout: rd_data <= selected value on every edge, giving 1-cycle latency.
  - sel 0 = cyc, 1 = stl, 2..NUM_EV+1 = ev[sel-2].
  - Any other sel returns 0.
  - On the clr edge rd_data reflects pre-clear values. It returns 0 from the following edge.
- Reset asserted mid-run aborts immediately to IDLE with all state zeroed. No result is retained.

Test Plan:
- Reset, start, 10 cycles with stall high on cycles 3 and 4, then store 0xDEAD_BEEF to 0x7fff -> done=1, result=0xDEADBEEF, cyc=11, stl=2, running=0.
- MAX_CYC=20, start, no halt store -> timeout=1 after the 20th counted cycle, cyc=20, later cycles leave cyc at 20.
- MAX_CYC=20, halt store on the 20th cycle -> done=1, timeout=0, result captured.
- CNT_W=4, SAT=1, 20 RUN cycles -> cyc=15, ovf=1. Repeat with SAT=0 -> cyc=4, ovf=1.
- event=4'b0101 for 6 RUN cycles, rd_sel stepped 2..5 -> rd_data 6, 0, 6, 0, each one cycle after sel. rd_sel=9 -> 0.
- clr and start asserted together in DONE -> IDLE with counters 0. rst_n low mid-run (async, between edges) -> outputs 0 immediately.
- Store to 0x7ffe, and a store to 0x7fff with memwrite=0 -> no termination, running stays 1.
